// File: rtl/mcycle_ctrl_pkg.sv
// mcycle_ctrl_pkg: shared widths, ALU/RV encodings, states, instruction classes and decoder.
// Optional MCYCLE_CTRL_BRANCH_EN adds BEQ/BNE decoding.
package mcycle_ctrl_pkg;
  localparam int CPU_WIDTH = 32;
  localparam int ALU_OP_WIDTH = 4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = ALU_OP_WIDTH'(1);
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_NPC, S_COMMIT} state_e;
  typedef enum logic [3:0] {C_ILL, C_ADDI, C_ADD, C_SUB, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BEQ, C_BNE} cls_e;
  function automatic cls_e decode(input logic [31:0] i);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    case (i[6:0])
      OP_IMM:   return f3 == F3_ADD ? C_ADDI : C_ILL;
      OP_REG:   return f3 != F3_ADD ? C_ILL : f7 == F7_ADD ? C_ADD : f7 == F7_SUB ? C_SUB : C_ILL;
      OP_LUI:   return C_LUI;
      OP_AUIPC: return C_AUIPC;
      OP_JAL:   return C_JAL;
      OP_JALR:  return f3 == F3_ADD ? C_JALR : C_ILL;
`ifdef MCYCLE_CTRL_BRANCH_EN
      OP_BRANCH: return f3 == F3_BEQ ? C_BEQ : f3 == F3_BNE ? C_BNE : C_ILL;
`endif
      default:  return C_ILL;
    endcase
  endfunction
  function automatic logic writes_rd(input cls_e c);
    return !(c inside {C_ILL, C_BEQ, C_BNE});
  endfunction
endpackage

// File: rtl/mcycle_ctrl_imm_gen.sv
// mcycle_ctrl_imm_gen: I/U/J/B immediate extraction, sign-extended to CPU_WIDTH.
module mcycle_ctrl_imm_gen
  import mcycle_ctrl_pkg::*;
(
  input  logic [31:7]          inst_i,
  input  cls_e                 cls_i,
  output logic [CPU_WIDTH-1:0] imm_o
);
  logic [CPU_WIDTH-1:0] i_imm, u_imm, j_imm, b_imm;
  assign i_imm = CPU_WIDTH'($signed(inst_i[31:20]));
  assign u_imm = CPU_WIDTH'($signed({inst_i[31:12], 12'b0}));
  assign j_imm = CPU_WIDTH'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  assign b_imm = CPU_WIDTH'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_o = cls_i inside {C_LUI, C_AUIPC} ? u_imm :
                 cls_i == C_JAL ? j_imm :
                 cls_i inside {C_BEQ, C_BNE} ? b_imm : i_imm;
endmodule

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: 4-state multi-cycle execute sequencer driving an external combinational ALU.
// Define MCYCLE_CTRL_BRANCH_EN to build BEQ/BNE support.
module mcycle_ctrl
  import mcycle_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_valid,
  output logic                    inst_ready,
  input  logic [31:0]             inst,
  input  logic [CPU_WIDTH-1:0]    inst_pc,
  output logic [4:0]              rs1_addr,
  output logic [4:0]              rs2_addr,
  input  logic [CPU_WIDTH-1:0]    rs1_data,
  input  logic [CPU_WIDTH-1:0]    rs2_data,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic [CPU_WIDTH-1:0]    alu_src1,
  output logic [CPU_WIDTH-1:0]    alu_src2,
  input  logic [CPU_WIDTH-1:0]    alu_res,
  input  logic                    zero,
  output logic                    rd_we,
  output logic [4:0]              rd_addr,
  output logic [CPU_WIDTH-1:0]    rd_wdata,
  output logic                    pc_we,
  output logic [CPU_WIDTH-1:0]    next_pc,
  output logic                    illegal
);
  state_e state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d, res_q, res_d, npc_q, npc_d, link_q, link_d, imm, src1, src2;
  logic [ALU_OP_WIDTH-1:0] op;
  logic taken, commit, jump;
  cls_e cls, cls_in;
  assign cls = decode(inst_q);
  assign cls_in = decode(inst);
  assign jump = cls inside {C_JAL, C_JALR};
  mcycle_ctrl_imm_gen u_imm (.inst_i(inst_q[31:7]), .cls_i(cls), .imm_o(imm));
`ifdef MCYCLE_CTRL_BRANCH_EN
  logic z_q;
  always_ff @(posedge clk)
    if (rst) z_q <= 1'b0;
    else if (state_q == S_EXEC) z_q <= zero;
  assign taken = (cls == C_BEQ && z_q) || (cls == C_BNE && !z_q);
`else
  logic unused_zero;
  assign unused_zero = zero;
  assign taken = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    inst_d = inst_q;
    pc_d = pc_q;
    res_d = res_q;
    npc_d = npc_q;
    link_d = link_q;
    op = ALU_ADD;
    src1 = '0;
    src2 = '0;
    case (state_q)
      S_IDLE: if (inst_valid) begin
        inst_d = inst;
        pc_d = inst_pc;
        state_d = cls_in == C_ILL ? S_COMMIT : S_EXEC;
      end
      S_EXEC: begin
        op = cls inside {C_SUB, C_BEQ, C_BNE} ? ALU_SUB : ALU_ADD;
        src1 = cls inside {C_ADDI, C_JALR, C_ADD, C_SUB, C_BEQ, C_BNE} ? rs1_data :
               cls == C_LUI ? '0 : pc_q;
        src2 = cls inside {C_ADD, C_SUB, C_BEQ, C_BNE} ? rs2_data : imm;
        res_d = alu_res;
        state_d = S_NPC;
      end
      S_NPC: begin
        src1 = pc_q;
        src2 = taken ? imm : CPU_WIDTH'(4);
        link_d = jump ? alu_res : link_q;
        npc_d = cls == C_JALR ? {res_q[CPU_WIDTH-1:1], 1'b0} : cls == C_JAL ? res_q : alu_res;
        state_d = S_COMMIT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= S_IDLE;
      inst_q <= '0;
      pc_q <= '0;
      res_q <= '0;
      npc_q <= '0;
      link_q <= '0;
    end else begin
      state_q <= state_d;
      inst_q <= inst_d;
      pc_q <= pc_d;
      res_q <= res_d;
      npc_q <= npc_d;
      link_q <= link_d;
    end
  // Every output is forced quiet while rst is high, whatever state is being abandoned.
  assign commit = state_q == S_COMMIT && !rst;
  assign inst_ready = state_q == S_IDLE && !rst;
  assign rs1_addr = rst ? '0 : inst_q[19:15];
  assign rs2_addr = rst ? '0 : inst_q[24:20];
  assign alu_op = rst ? ALU_ADD : op;
  assign alu_src1 = rst ? '0 : src1;
  assign alu_src2 = rst ? '0 : src2;
  assign rd_we = commit && writes_rd(cls) && inst_q[11:7] != 5'd0;
  assign rd_addr = commit ? inst_q[11:7] : '0;
  assign rd_wdata = !commit ? '0 : jump ? link_q : res_q;
  assign pc_we = commit && cls != C_ILL;
  assign next_pc = commit ? npc_q : '0;
  assign illegal = commit && cls == C_ILL;
endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: scoreboard bench for mcycle_ctrl with a behavioural ALU and regfile.
module tb_mcycle_ctrl;
  import mcycle_ctrl_pkg::*;
  logic clk = 1'b0, rst = 1'b1, inst_valid = 1'b0;
  logic inst_ready, zero, rd_we, pc_we, illegal;
  logic [31:0] inst = '0;
  logic [CPU_WIDTH-1:0] inst_pc = '0, rs1_data, rs2_data, alu_src1, alu_src2, alu_res, rd_wdata, next_pc;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic [31:0] rf [32];
  typedef struct {logic ill; logic we; logic [4:0] rd; logic [31:0] wd; logic [31:0] npc; int cyc;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_err = 0, cyc = 0, w;
  mcycle_ctrl dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_res(alu_res), .zero(zero),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata), .pc_we(pc_we), .next_pc(next_pc), .illegal(illegal)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];
  assign alu_res = alu_op == ALU_ADD ? alu_src1 + alu_src2 : alu_src1 - alu_src2;
  assign zero = alu_res == '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rst) begin
      check("rst_ready", {31'b0, inst_ready}, 0);
      check("rst_strobes", {29'b0, rd_we, pc_we, illegal}, 0);
      check("rst_next_pc", next_pc, 0);
    end else if (rd_we || pc_we || illegal) begin
      if (q.size() == 0) check("spurious_commit", 1, 0);
      else begin
        e = q.pop_front();
        check("illegal", {31'b0, illegal}, {31'b0, e.ill});
        check("pc_we", {31'b0, pc_we}, {31'b0, !e.ill});
        check("rd_we", {31'b0, rd_we}, {31'b0, e.we});
        if (e.we) begin
          check("rd_addr", {27'b0, rd_addr}, {27'b0, e.rd});
          check("rd_wdata", rd_wdata, e.wd);
        end
        if (!e.ill) check("next_pc", next_pc, e.npc);
        check("commit_cycle", cyc, e.cyc);
      end
    end
  // Inputs change just after a rising edge; the handshake is seen on the following falling edge.
  task automatic send(input logic [31:0] i, input logic [31:0] pc, input logic ill, input logic we,
                      input logic [31:0] wd, input logic [31:0] npc, output int waits);
    exp_t x;
    inst = i;
    inst_pc = pc;
    inst_valid = 1'b1;
    waits = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (inst_ready) break;
      waits++;
    end
    if (!inst_ready) check("handshake_timeout", 0, 1);
    else begin
      x.ill = ill; x.we = we; x.rd = i[11:7]; x.wd = wd; x.npc = npc;
      x.cyc = cyc + (ill ? 1 : 3);
      q.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic one(input logic [31:0] i, input logic [31:0] pc, input logic ill, input logic we,
                     input logic [31:0] wd, input logic [31:0] npc);
    int k;
    send(i, pc, ill, we, wd, npc, k);
    inst_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (inst_ready) break;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic br(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] npc);
`ifdef MCYCLE_CTRL_BRANCH_EN
    one(i, pc, 1'b0, 1'b0, '0, npc);
`else
    one(i, pc, 1'b1, 1'b0, '0, npc);
`endif
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    logic [11:0] imm;
    logic [4:0] rs, rd;
    foreach (rf[k]) rf[k] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, inst_ready}, 1);
    @(posedge clk);
    #1;
    one(32'hFFD00293, 32'h80000000, 0, 1, 32'hFFFFFFFD, 32'h80000004);
    rf[6] = 32'd7; rf[7] = 32'd7;
    br(32'h00730863, 32'h80000010, 32'h80000020);
    rf[7] = 32'd8;
    br(32'h00730863, 32'h80000010, 32'h80000014);
    br(32'h00731863, 32'h80000010, 32'h80000020);
    rf[2] = 32'h80001003;
    one(32'h004100E7, 32'h80000100, 0, 1, 32'h80000104, 32'h80001006);
    rf[3] = 32'd5; rf[4] = 32'd9;
    one(32'h00418033, 32'h80000040, 0, 0, 32'd14, 32'h80000044);
    one(32'h12345537, 32'h80000050, 0, 1, 32'h12345000, 32'h80000054);
    one(32'h00001597, 32'h80000200, 0, 1, 32'h80001200, 32'h80000204);
    one(32'h008000EF, 32'h80000300, 0, 1, 32'h80000304, 32'h80000308);
    one(32'h40730633, 32'h80000060, 0, 1, 32'hFFFFFFFF, 32'h80000064);
    one(32'hFFFFFFFF, 32'h80000070, 1, 0, '0, '0);
    one(32'h02418033, 32'h80000074, 1, 0, '0, '0);
    for (int n = 0; n < 4; n++) begin
      imm = 12'($urandom);
      rs = 5'($urandom_range(16, 31));
      rd = 5'($urandom_range(0, 31));
      rf[rs] = $urandom;
      one({imm, rs, 3'b000, rd, 7'h13}, 32'h80000800 + 32'(n * 4), 0, rd != 0,
          rf[rs] + {{20{imm[11]}}, imm}, 32'h80000804 + 32'(n * 4));
    end
    send(32'h007306B3, 32'h80000400, 0, 1, 32'd15, 32'h80000404, w);
    check("b2b_first_waits", w, 0);
    send(32'h40730733, 32'h80000404, 0, 1, 32'hFFFFFFFF, 32'h80000408, w);
    check("b2b_second_waits", w, 3);
    inst_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    send(32'hFFD00293, 32'h80000500, 0, 1, 32'hFFFFFFFD, 32'h80000504, w);
    inst_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", {31'b0, inst_ready}, 1);
    repeat (6) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
